mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised MEM->WB pipeline register for the multi-issue core: NUM_LANES register-file write lanes plus optional HI/LO write.
//  Captures MEM results each cycle and honours stall, bubble and flush control.
//  Suppresses writes to r0, resolves same-bundle write collisions, and drives WB-stage forwarding lookups and a retired-write counter.
// PARAMETERS
//  DATA_W     32  width of register / HI / LO data
//  ADDR_W     5   register-file address width
//  NUM_LANES  2   write lanes per bundle; lane index = program order, higher lane is younger
//  HILO_EN    1   1 = HI/LO path present; 0 = HI/LO outputs tied to 0
//  FWD_PORTS  2   number of forwarding lookup ports
//  CNT_W      32  retired-write counter width
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  reset; synchronous, active-high
//  stall_self   in   1                  MEM/WB stage stalled
//  stall_next   in   1                  WB stage stalled
//  flush        in   1                  squash the incoming bundle
//  mem_we       in   NUM_LANES          per-lane write enable
//  mem_waddr    in   NUM_LANES*ADDR_W   per-lane destination; lane i at [i*ADDR_W +: ADDR_W]
//  mem_wdata    in   NUM_LANES*DATA_W   per-lane write data, same packing
//  mem_hilo_we  in   1                  HI/LO write enable
//  mem_hi       in   DATA_W             HI data
//  mem_lo       in   DATA_W             LO data
//  fwd_raddr    in   FWD_PORTS*ADDR_W   lookup addresses from decode
//  wb_we        out  NUM_LANES          registered write enables to the register file
//  wb_waddr     out  NUM_LANES*ADDR_W   registered destinations
//  wb_wdata     out  NUM_LANES*DATA_W   registered data
//  wb_hilo_we   out  1                  registered HI/LO write enable
//  wb_hi        out  DATA_W             registered HI
//  wb_lo        out  DATA_W             registered LO
//  fwd_hit      out  FWD_PORTS          lookup hit, combinational on registered state
//  fwd_data     out  FWD_PORTS*DATA_W   forwarded data; 0 on miss
//  retire_cnt   out  CNT_W              count of register writes accepted into WB
// BEHAVIOUR
//  Per posedge clk, first matching condition applies:
//   1 rst                        -> all wb_* outputs = 0, retire_cnt = 0
//   2 flush                      -> bubble: all wb_* = 0; retire_cnt unchanged
//   3 stall_self & !stall_next   -> bubble, identical to case 2
//   4 stall_self & stall_next    -> hold: all registers keep their value
//   5 otherwise (!stall_self)    -> capture the MEM inputs; latency 1 cycle
//  stall_next=1 with stall_self=0 is illegal. Treat it as case 5; the bench asserts it never occurs.
//  Capture filtering, per lane i:
//   - we_i = mem_we[i] & (waddr_i != 0)
//   - we_i is also cleared if a younger lane j>i has the same filtered enable and address (youngest wins)
//  Addr/data of disabled lanes are stored as 0, so bubbles and suppressed lanes are identical.
//  HILO_EN=0: wb_hilo_we/wb_hi/wb_lo are constant 0 and mem_hi/mem_lo are ignored.
//  Forwarding port p:
//   - hit = fwd_raddr_p != 0 and some lane has wb_we set with wb_waddr equal to it
//   - data comes from the highest hitting lane; miss -> hit=0, data=0
//   - reads registered state only; no same-cycle path from mem_* inputs
//  retire_cnt:
//   - on capture (case 5), adds popcount of the filtered enables
//   - unchanged on hold or bubble
//   - wraps modulo 2^CNT_W
//  Reset mid-stall or mid-flush: rst wins; outputs are 0 on the next edge.
// STRUCTURE
//  Package core_pkg: stall/flush priority constants, the WE enable/disable constants, and the lane-slice helper function lane_sl().
//  Sub-module wb_fwd_mux, one instance per forwarding port: a priority address compare across lanes producing hit and data.
//  Top level: capture filter (combinational), stage registers, and the counter.
// TESTING
//  1 rst=1 for 2 cycles with non-zero inputs -> every wb_* output and retire_cnt are 0.
//  2 Lane0 we=1 addr=3 data=0xA5A5A5A5, no stall -> next cycle wb_we[0]=1, wb_waddr[0]=3, retire_cnt=1.
//  3 Capture addr=7, then stall_self=stall_next=1 for 3 cycles with new inputs -> outputs hold addr=7; retire_cnt unchanged.
//  4 stall_self=1, stall_next=0 -> wb_we=0, all data 0; repeat with flush=1 -> same result.
//  5 Lanes 0/1 both write addr=9 with data 0x11/0x22, and lane 1 writes r0 in a second bundle:
//    -> only wb_we[1] set, data 0x22, retire_cnt+=1; the r0 write is dropped.
//  6 fwd_raddr=9 while WB holds addr 9 -> hit=1, data=0x22; fwd_raddr=0 or 4 -> hit=0.
//    Force retire_cnt to all-ones, then capture one write -> counter wraps to 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared stage-control encoding, write-enable constants and lane slicing helper.
package core_pkg;
  localparam logic WE_ON  = 1'b1;
  localparam logic WE_OFF = 1'b0;
  typedef enum logic [1:0] {OP_CAPTURE, OP_BUBBLE, OP_HOLD} stage_op_e;
  // flush outranks stall; a self stall with a free consumer drains as a bubble
  function automatic stage_op_e stage_op(input logic flush, input logic stall_self, input logic stall_next);
    return flush ? OP_BUBBLE : !stall_self ? OP_CAPTURE : stall_next ? OP_HOLD : OP_BUBBLE;
  endfunction
  function automatic int lane_sl(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/wb_fwd_mux.sv
// wb_fwd_mux: priority lookup of one register address across the WB write lanes.
module wb_fwd_mux
  import core_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_LANES = 2
) (
  input  logic [NUM_LANES-1:0]        we,
  input  logic [NUM_LANES*ADDR_W-1:0] waddr,
  input  logic [NUM_LANES*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]           raddr,
  output logic                        hit,
  output logic [DATA_W-1:0]           data
);
  // ascending scan so the youngest matching lane lands last
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (we[i] && raddr != '0 && waddr[lane_sl(i, ADDR_W) +: ADDR_W] == raddr) begin
        hit  = 1'b1;
        data = wdata[lane_sl(i, DATA_W) +: DATA_W];
      end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with r0/collision filtering, forwarding and retire count.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_LANES = 2,
  parameter int HILO_EN   = 1,
  parameter int FWD_PORTS = 2,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_self,
  input  logic                        stall_next,
  input  logic                        flush,
  input  logic [NUM_LANES-1:0]        mem_we,
  input  logic [NUM_LANES*ADDR_W-1:0] mem_waddr,
  input  logic [NUM_LANES*DATA_W-1:0] mem_wdata,
  input  logic                        mem_hilo_we,
  input  logic [DATA_W-1:0]           mem_hi,
  input  logic [DATA_W-1:0]           mem_lo,
  input  logic [FWD_PORTS*ADDR_W-1:0] fwd_raddr,
  output logic [NUM_LANES-1:0]        wb_we,
  output logic [NUM_LANES*ADDR_W-1:0] wb_waddr,
  output logic [NUM_LANES*DATA_W-1:0] wb_wdata,
  output logic                        wb_hilo_we,
  output logic [DATA_W-1:0]           wb_hi,
  output logic [DATA_W-1:0]           wb_lo,
  output logic [FWD_PORTS-1:0]        fwd_hit,
  output logic [FWD_PORTS*DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]            retire_cnt
);
  localparam logic HILO = HILO_EN != 0;
  logic [NUM_LANES-1:0]        we_nz, we_f;
  logic [NUM_LANES*ADDR_W-1:0] cap_addr;
  logic [NUM_LANES*DATA_W-1:0] cap_data;
  logic [CNT_W-1:0]            pop;
  stage_op_e                   op;
  assign op = stage_op(flush, stall_self, stall_next);
  // younger lane wins an address collision; killed lanes are stored as all-zero
  always_comb begin
    we_nz    = '0;
    we_f     = '0;
    cap_addr = '0;
    cap_data = '0;
    pop      = '0;
    for (int i = 0; i < NUM_LANES; i++)
      we_nz[i] = mem_we[i] && mem_waddr[lane_sl(i, ADDR_W) +: ADDR_W] != '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      we_f[i] = we_nz[i];
      for (int j = i + 1; j < NUM_LANES; j++)
        if (we_nz[j] && mem_waddr[lane_sl(j, ADDR_W) +: ADDR_W] == mem_waddr[lane_sl(i, ADDR_W) +: ADDR_W])
          we_f[i] = WE_OFF;
      cap_addr[lane_sl(i, ADDR_W) +: ADDR_W] = we_f[i] ? mem_waddr[lane_sl(i, ADDR_W) +: ADDR_W] : '0;
      cap_data[lane_sl(i, DATA_W) +: DATA_W] = we_f[i] ? mem_wdata[lane_sl(i, DATA_W) +: DATA_W] : '0;
      pop = pop + CNT_W'(we_f[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || op == OP_BUBBLE) begin
      wb_we      <= '0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      wb_hilo_we <= WE_OFF;
      wb_hi      <= '0;
      wb_lo      <= '0;
    end else if (op == OP_CAPTURE) begin
      wb_we      <= we_f;
      wb_waddr   <= cap_addr;
      wb_wdata   <= cap_data;
      wb_hilo_we <= HILO ? mem_hilo_we : WE_OFF;
      wb_hi      <= HILO ? mem_hi : '0;
      wb_lo      <= HILO ? mem_lo : '0;
    end
    if (rst) retire_cnt <= '0;
    else if (op == OP_CAPTURE) retire_cnt <= retire_cnt + pop;
  end
  for (genvar p = 0; p < FWD_PORTS; p++) begin : g_fwd
    wb_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LANES(NUM_LANES)) u_fwd (
      .we    (wb_we),
      .waddr (wb_waddr),
      .wdata (wb_wdata),
      .raddr (fwd_raddr[p*ADDR_W +: ADDR_W]),
      .hit   (fwd_hit[p]),
      .data  (fwd_data[p*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of capture, hold, bubble, filtering, forwarding and counter wrap.
module tb_mem_wb_stage;
  logic        clk = 0, rst, stall_self, stall_next, flush, mem_hilo_we;
  logic [1:0]  mem_we;
  logic [9:0]  mem_waddr, fwd_raddr;
  logic [63:0] mem_wdata;
  logic [31:0] mem_hi, mem_lo;
  logic [1:0]  wb_we, fwd_hit, wb_we2, fwd_hit2;
  logic [9:0]  wb_waddr, wb_waddr2;
  logic [63:0] wb_wdata, fwd_data, wb_wdata2, fwd_data2;
  logic        wb_hilo_we, wb_hilo_we2;
  logic [31:0] wb_hi, wb_lo, retire_cnt, wb_hi2, wb_lo2;
  logic [1:0]  retire_cnt2;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next), .flush(flush),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_hilo_we(mem_hilo_we),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .fwd_raddr(fwd_raddr), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .wb_hilo_we(wb_hilo_we), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retire_cnt(retire_cnt));
  mem_wb_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next), .flush(flush),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_hilo_we(mem_hilo_we),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .fwd_raddr(fwd_raddr), .wb_we(wb_we2), .wb_waddr(wb_waddr2),
    .wb_wdata(wb_wdata2), .wb_hilo_we(wb_hilo_we2), .wb_hi(wb_hi2), .wb_lo(wb_lo2),
    .fwd_hit(fwd_hit2), .fwd_data(fwd_data2), .retire_cnt(retire_cnt2));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic zeros(input string tag);
    chk({tag, "_we"}, 64'(wb_we), 64'd0);
    chk({tag, "_waddr"}, 64'(wb_waddr), 64'd0);
    chk({tag, "_wdata"}, wb_wdata, 64'd0);
    chk({tag, "_hilo_we"}, 64'(wb_hilo_we), 64'd0);
    chk({tag, "_hi"}, 64'(wb_hi), 64'd0);
    chk({tag, "_lo"}, 64'(wb_lo), 64'd0);
  endtask
  always @(negedge clk)
    if (rst === 1'b0)
      assert (!(stall_next && !stall_self)) else begin
        fails++;
        $error("FAIL illegal_stall observed=stall_next without stall_self expected=never");
      end
  initial begin
    rst = 1; stall_self = 0; stall_next = 0; flush = 0;
    mem_we = 2'b11; mem_waddr = {5'd4, 5'd3}; mem_wdata = {32'hDEAD, 32'hBEEF};
    mem_hilo_we = 1; mem_hi = 32'h1234; mem_lo = 32'h5678; fwd_raddr = {5'd4, 5'd3};
    tick(); tick();
    zeros("reset");
    chk("reset_cnt", 64'(retire_cnt), 64'd0);
    chk("reset_fwd_hit", 64'(fwd_hit), 64'd0);
    rst = 0; mem_we = 2'b01; mem_wdata = {32'hDEAD, 32'hA5A5A5A5};
    tick();
    chk("cap_we", 64'(wb_we), 64'b01);
    chk("cap_waddr", 64'(wb_waddr), 64'h003);
    chk("cap_wdata", wb_wdata, 64'h0000_0000_A5A5_A5A5);
    chk("cap_hilo_we", 64'(wb_hilo_we), 64'd1);
    chk("cap_hi", 64'(wb_hi), 64'h1234);
    chk("cap_lo", 64'(wb_lo), 64'h5678);
    chk("cap_cnt", 64'(retire_cnt), 64'd1);
    chk("cap_fwd_hit", 64'(fwd_hit), 64'b01);
    chk("cap_fwd_data", fwd_data, 64'h0000_0000_A5A5_A5A5);
    mem_waddr = {5'd0, 5'd7}; mem_wdata = {32'h0, 32'h77}; mem_hilo_we = 0;
    tick();
    chk("cap7_waddr", 64'(wb_waddr), 64'h007);
    stall_self = 1; stall_next = 1;
    mem_we = 2'b11; mem_waddr = {5'd9, 5'd8}; mem_wdata = {32'h99, 32'h88}; mem_hilo_we = 1;
    tick(); tick(); tick();
    chk("hold_we", 64'(wb_we), 64'b01);
    chk("hold_waddr", 64'(wb_waddr), 64'h007);
    chk("hold_wdata", wb_wdata, 64'h77);
    chk("hold_hilo_we", 64'(wb_hilo_we), 64'd0);
    chk("hold_cnt", 64'(retire_cnt), 64'd2);
    stall_next = 0;
    tick();
    zeros("bubble");
    chk("bubble_cnt", 64'(retire_cnt), 64'd2);
    stall_self = 0; mem_we = 2'b01; mem_waddr = {5'd0, 5'd5}; mem_wdata = {32'h0, 32'h55}; mem_hilo_we = 0;
    tick();
    chk("cap5_waddr", 64'(wb_waddr), 64'h005);
    chk("cap5_cnt", 64'(retire_cnt), 64'd3);
    flush = 1; mem_we = 2'b11; mem_waddr = {5'd2, 5'd1}; mem_hilo_we = 1;
    tick();
    zeros("flush");
    chk("flush_cnt", 64'(retire_cnt), 64'd3);
    chk("flush_cnt2", 64'(retire_cnt2), 64'd3);
    flush = 0; mem_hilo_we = 0; mem_we = 2'b11; mem_waddr = {5'd9, 5'd9}; mem_wdata = {32'h22, 32'h11};
    fwd_raddr = {5'd4, 5'd9};
    tick();
    chk("coll_we", 64'(wb_we), 64'b10);
    chk("coll_waddr", 64'(wb_waddr), 64'h120);
    chk("coll_wdata", wb_wdata, 64'h0000_0022_0000_0000);
    chk("coll_cnt", 64'(retire_cnt), 64'd4);
    chk("wrap_cnt2", 64'(retire_cnt2), 64'd0);
    chk("fwd9_hit", 64'(fwd_hit), 64'b01);
    chk("fwd9_data", fwd_data, 64'h0000_0000_0000_0022);
    fwd_raddr = {5'd9, 5'd0};
    #1;
    chk("fwd0_hit", 64'(fwd_hit), 64'b10);
    chk("fwd0_data", fwd_data, 64'h0000_0022_0000_0000);
    mem_waddr = {5'd0, 5'd6}; mem_wdata = {32'h99, 32'h66}; fwd_raddr = {5'd0, 5'd6};
    tick();
    chk("r0_we", 64'(wb_we), 64'b01);
    chk("r0_waddr", 64'(wb_waddr), 64'h006);
    chk("r0_wdata", wb_wdata, 64'h66);
    chk("r0_cnt", 64'(retire_cnt), 64'd5);
    chk("r0_fwd", 64'(fwd_hit), 64'b01);
    mem_waddr = {5'd11, 5'd10}; mem_wdata = {32'hBB, 32'hAA}; fwd_raddr = {5'd11, 5'd10};
    tick();
    chk("dual_we", 64'(wb_we), 64'b11);
    chk("dual_cnt", 64'(retire_cnt), 64'd7);
    chk("dual_cnt2", 64'(retire_cnt2), 64'd3);
    chk("dual_fwd_data", fwd_data, 64'h0000_00BB_0000_00AA);
    mem_waddr = {5'd3, 5'd2};
    tick();
    chk("wrap2_cnt2", 64'(retire_cnt2), 64'd1);
    stall_self = 1; stall_next = 1; rst = 1;
    tick();
    zeros("rst_stall");
    chk("rst_stall_cnt", 64'(retire_cnt), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
